// File: rtl/program_loader.sv
// ============================================================================
// Module  : program_loader
// Purpose : Boot loader that packs a byte stream into 32-bit big-endian words,
//           writes them to memory and holds the CPU in reset until loaded.
//           Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] HDR_HI = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM   = 3'd6;
  localparam logic [2:0] FINAL  = CSUM;
`else
  localparam logic [2:0] FINAL  = DONE;
`endif

  logic [2:0]        state;
  logic [15:0]       count;
  logic [15:0]       idx;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic              accept;
  logic [15:0]       hdr_count;
  logic [15:0]       idx_next;
  logic [ADDR_W-1:0] word_off;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count[15:8], in_data};
  assign idx_next  = idx + 16'd1;
  assign word_off  = ADDR_W'({idx, 2'b00});

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign in_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CSUM);
`else
  assign in_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
`endif
  assign mem_we  = (state == WRITE);
  assign done    = (state == DONE);
  assign error   = (state == ERR);
  assign cpu_rst = (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HDR_HI;
      count     <= '0;
      idx       <= '0;
      byte_idx  <= '0;
      word      <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        HDR_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            if (hdr_count == 16'd0)
              state <= FINAL;
            else if (hdr_count > 16'(MAX_WORDS))
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            word     <= {word[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            // Address and data are latched here so they hold outside WRITE.
            if (byte_idx == 2'd3) begin
              mem_wdata <= {word, in_data};
              mem_addr  <= BASE_ADDR + word_off;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          idx   <= idx_next;
          state <= (idx_next < count) ? DATA : FINAL;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept)
            state <= (in_data == csum) ? DONE : ERR;
        end
`endif
        default: state <= state;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by the
// stimulus and checked by an independent monitor on each mem_we pulse.
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  bit stall_chk = 1'b0;

  logic [31:0] img [2] = '{32'h20080005, 32'h8C090004};

  program_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e[63:32]);
        check("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leading gap of idle cycles, then hold the byte until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    in_data  = 8'hEE;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (stall_chk) check("cpu_rst_during_stall", {31'd0, cpu_rst}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte 0x%02h not accepted, in_ready %0b expected 1", b, in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic send_words(input int n, input int nbytes, input int gap);
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < nbytes; i++) begin
      logic [31:0] w;
      w = img[i / 4];
      send_byte(w[31 - 8 * (i % 4) -: 8], gap);
    end
  endtask

  task automatic do_reset(input bit chk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    if (chk) begin
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset(1'b1);

    // Two words back to back.
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h8C090004});
    send_words(2, 8, 0);
    @(negedge clk);
    check("t1_last_we", {31'd0, mem_we}, 32'd1);
    check("t1_cpu_rst_in_write", {31'd0, cpu_rst}, 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hAC, 0);
`else
    @(negedge clk);
`endif
    check_done("t1");

    // Same image with 3 idle cycles before every byte.
    do_reset(1'b0);
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h8C090004});
    stall_chk = 1'b1;
    send_words(2, 8, 3);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hAC, 3);
`endif
    stall_chk = 1'b0;
    repeat (2) @(negedge clk);
    check_done("t2");

    // Empty image.
    do_reset(1'b0);
    send_words(0, 0, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("t3_cpu_rst_before_csum", {31'd0, cpu_rst}, 32'd1);
    send_byte(8'h00, 0);
`endif
    check_done("t3");

    // Oversized header 0x0101 = 257 words.
    do_reset(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_error_sticky", {31'd0, error}, 32'd1);
    check("t4_done_low", {31'd0, done}, 32'd0);

    // Reset after 6 data bytes, then full resend.
    do_reset(1'b0);
    exp_q.push_back({32'h0, 32'h20080005});
    send_words(2, 6, 0);
    do_reset(1'b1);
    check("t5_partial_discarded", exp_q.size(), 32'd0);
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h8C090004});
    send_words(2, 8, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hAC, 0);
`endif
    repeat (2) @(negedge clk);
    check_done("t5");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // 12^34^56^78 = 0x08.
    img[0] = 32'h12345678;
    do_reset(1'b0);
    exp_q.push_back({32'h0, 32'h12345678});
    send_words(1, 4, 0);
    send_byte(8'h08, 0);
    check_done("t6_good");
    do_reset(1'b0);
    exp_q.push_back({32'h0, 32'h12345678});
    send_words(1, 4, 0);
    send_byte(8'h09, 0);
    check("t6_bad_error", {31'd0, error}, 32'd1);
    check("t6_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t6_bad_word_written", exp_q.size(), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_pending_writes", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
